qed_encoder: RTL and testbench

Re-assembles a 32-bit RV32I instruction from decoded slot fields, the inverse of the QED field decoder, and registers it through a valid/ready stage.
- Optional QED register remap: when enabled, register operands are moved from the original bank (x1..x15) to the duplicate bank (x17..x31). x0 is never remapped.
- Sits between the QED field decoder and the instruction mux that feeds the core fetch path.

---
 rtl/qed_pkg.sv | 44 ++++
 rtl/qed_skid_buffer.sv | 77 +++++++
 rtl/qed_encoder.sv | 101 ++++++++++
 tb/tb_qed_encoder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/qed_pkg.sv
// Shared constants for the QED field decoder/encoder pair: opcode classes,
// the default remap bit, the NOP word, and the opcode->format classifier.
package qed_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LW     = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_SW     = 7'b0100011;
  localparam logic [6:0] OPC_B      = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_J      = 7'b1101111;

  localparam int          REMAP_BIT_DEF = 4;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  // Instruction layout families; FMT_SYS is I-layout without remap,
  // FMT_SB has an immediate in the rd slot.
  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_SYS,
    FMT_SB,
    FMT_UJ,
    FMT_BAD
  } fmt_e;

  function automatic fmt_e opc_fmt(input logic [6:0] opc);
    fmt_e f;
    case (opc)
      OPC_R:                      f = FMT_R;
      OPC_I, OPC_LW, OPC_JALR:    f = FMT_I;
      OPC_FENCE, OPC_SYSTEM:      f = FMT_SYS;
      OPC_SW, OPC_B:              f = FMT_SB;
      OPC_LUI, OPC_AUIPC, OPC_J:  f = FMT_UJ;
      default:                    f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/qed_skid_buffer.sv
// Generic 2-entry valid/ready stage: a main output register plus one skid
// register. in_ready is registered and means "skid register empty", so the
// upstream ready path never depends combinationally on out_ready.
module qed_skid_buffer
  import qed_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             rdy_q, rdy_d;

  logic in_xfer, out_xfer;

  assign in_xfer   = in_valid && rdy_q;
  assign out_xfer  = vld_q && out_ready;
  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign out_data  = data_q;

  // Next-state: skid drains first; otherwise new words go to the output
  // register if it is free/draining, else park in the skid register.
  always_comb begin
    vld_d      = vld_q;
    data_d     = data_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    if (skid_vld_q) begin
      // rdy_q is low here, so no input transfer can coincide
      if (out_xfer) begin
        data_d     = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (in_xfer) begin
      if (!vld_q || out_ready) begin
        data_d = in_data;
        vld_d  = 1'b1;
      end else begin
        skid_d     = in_data;
        skid_vld_d = 1'b1;
      end
    end else if (out_xfer) begin
      vld_d = 1'b0;
    end
    rdy_d = !skid_vld_d;
  end

  // State registers; reset empties both entries immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= 1'b0;
      data_q     <= '0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
      rdy_q      <= 1'b1;
    end else begin
      vld_q      <= vld_d;
      data_q     <= data_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
      rdy_q      <= rdy_d;
    end
  end

endmodule

// File: rtl/qed_encoder.sv
// Re-assembles an RV32I instruction from decoded slot fields, optionally
// moving register operands into the duplicate bank (x17..x31), and registers
// {illegal, instruction} through a 2-entry skid stage.
module qed_encoder
  import qed_pkg::*;
#(
  parameter int          REMAP_BIT = REMAP_BIT_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        qed_en,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [6:0]  funct7,
  input  logic [11:0] imm12,
  input  logic [19:0] uimm31,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] qed_instruction,
  output logic        illegal
);

  localparam logic [4:0] REMAP_MASK = 5'(1) << REMAP_BIT;

  // x0 is never remapped; any other index gets the bank bit forced on.
  function automatic logic [4:0] remap(input logic [4:0] r, input logic en);
    return (en && (r != 5'd0)) ? (r | REMAP_MASK) : r;
  endfunction

  // Operand already in the duplicate bank cannot be remapped cleanly.
  function automatic logic clash(input logic [4:0] r, input logic en);
    return en && ((r & REMAP_MASK) != 5'd0);
  endfunction

  logic [4:0]  rd_p, rs1_p, rs2_p;
  logic        rd_c, rs1_c, rs2_c;
  logic [31:0] enc_instr;
  logic        enc_illegal;
  logic [32:0] out_word;
  fmt_e        fmt;

  assign rd_p  = remap(rd,  qed_en);
  assign rs1_p = remap(rs1, qed_en);
  assign rs2_p = remap(rs2, qed_en);
  assign rd_c  = clash(rd,  qed_en);
  assign rs1_c = clash(rs1, qed_en);
  assign rs2_c = clash(rs2, qed_en);
  assign fmt   = opc_fmt(opcode);

  // Format mux; a conflict only counts for fields that are actually remapped.
  always_comb begin
    enc_instr   = NOP_INSTR;
    enc_illegal = 1'b0;
    case (fmt)
      FMT_R: begin
        enc_instr   = {funct7, rs2_p, rs1_p, funct3, rd_p, opcode};
        enc_illegal = rd_c || rs1_c || rs2_c;
      end
      FMT_I: begin
        enc_instr   = {imm12, rs1_p, funct3, rd_p, opcode};
        enc_illegal = rd_c || rs1_c;
      end
      FMT_SYS: begin
        enc_instr   = {imm12, rs1, funct3, rd, opcode};
      end
      FMT_SB: begin
        enc_instr   = {funct7, rs2_p, rs1_p, funct3, rd, opcode};
        enc_illegal = rs1_c || rs2_c;
      end
      FMT_UJ: begin
        enc_instr   = {uimm31, rd_p, opcode};
        enc_illegal = rd_c;
      end
      default: begin
        enc_instr   = NOP_INSTR;
        enc_illegal = 1'b1;
      end
    endcase
  end

  qed_skid_buffer #(.WIDTH(33)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({enc_illegal, enc_instr}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_word)
  );

  assign illegal         = out_word[32];
  assign qed_instruction = out_word[31:0];

endmodule

// File: tb/tb_qed_encoder.sv
// Scoreboard bench for qed_encoder: directed vectors with literal expected
// words, then randomized bundles against an arithmetic reference model.
module tb_qed_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        qed_en = 1'b0;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [6:0]  funct7 = '0;
  logic [11:0] imm12 = '0;
  logic [19:0] uimm31 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] qed_instruction;
  logic        illegal;

  int checks = 0;
  int failures = 0;
  logic [32:0] exp_q[$];
  logic        ready_cmd = 1'b1;
  logic        bp_mode = 1'b0;
  logic        stall_seen = 1'b0;
  logic [32:0] held = '0;
  logic [6:0]  opc_tab [11];

  qed_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .qed_en(qed_en), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1),
    .rs2(rs2), .funct7(funct7), .imm12(imm12), .uimm31(uimm31),
    .out_valid(out_valid), .out_ready(out_ready),
    .qed_instruction(qed_instruction), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Register index as seen after the remap rule: 1..15 move up by 16.
  function automatic int mapped(input int r, input bit en);
    return (en && r >= 1 && r <= 15) ? r + 16 : r;
  endfunction

  function automatic bit conflicted(input int r, input bit en);
    return en && r >= 16;
  endfunction

  // Reference: place each field by its bit weight, per instruction family.
  function automatic logic [32:0] model(input int op, input int d, input int f3,
      input int s1, input int s2, input int f7, input int imm, input int u, input bit en);
    longint w;
    bit bad;
    bad = 0;
    if (op == 'h33) begin
      w = f7 * 2**25 + mapped(s2, en) * 2**20 + mapped(s1, en) * 2**15 + f3 * 2**12 + mapped(d, en) * 2**7 + op;
      bad = conflicted(d, en) || conflicted(s1, en) || conflicted(s2, en);
    end else if (op == 'h13 || op == 'h03 || op == 'h67) begin
      w = imm * 2**20 + mapped(s1, en) * 2**15 + f3 * 2**12 + mapped(d, en) * 2**7 + op;
      bad = conflicted(d, en) || conflicted(s1, en);
    end else if (op == 'h0F || op == 'h73) begin
      w = imm * 2**20 + s1 * 2**15 + f3 * 2**12 + d * 2**7 + op;
    end else if (op == 'h23 || op == 'h63) begin
      w = f7 * 2**25 + mapped(s2, en) * 2**20 + mapped(s1, en) * 2**15 + f3 * 2**12 + d * 2**7 + op;
      bad = conflicted(s1, en) || conflicted(s2, en);
    end else if (op == 'h37 || op == 'h17 || op == 'h6F) begin
      w = u * 2**12 + mapped(d, en) * 2**7 + op;
      bad = conflicted(d, en);
    end else begin
      w = 'h13;
      bad = 1;
    end
    return {bad, w[31:0]};
  endfunction

  // Called at posedge+2; holds the bundle until accepted, returns at the next posedge+2.
  task automatic send(input int op, input int d, input int f3, input int s1, input int s2,
      input int f7, input int imm, input int u, input bit en, input logic [32:0] exp);
    int n;
    opcode = 7'(op); rd = 5'(d); funct3 = 3'(f3); rs1 = 5'(s1); rs2 = 5'(s2);
    funct7 = 7'(f7); imm12 = 12'(imm); uimm31 = 20'(u); qed_en = en;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 500) begin
      @(posedge clk); #2;
      n++;
    end
    if (!in_ready) begin
      $display("FAIL send_timeout: in_ready stuck at 0 after %0d cycles", n);
      $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
      $fatal(1);
    end
    exp_q.push_back(exp);
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Single driver of out_ready: random when bp_mode, else the commanded level.
  always @(posedge clk) begin
    #2;
    out_ready = bp_mode ? 1'($urandom_range(0, 1)) : ready_cmd;
  end

  // Monitor: pop/compare on every output transfer, and hold-stability under stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen && out_valid)
        check("stable", {illegal, qed_instruction}, held);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_out: got %h with empty scoreboard", {illegal, qed_instruction});
        end else begin
          check("out", {illegal, qed_instruction}, exp_q.pop_front());
        end
      end
      stall_seen = out_valid && !out_ready;
      held = {illegal, qed_instruction};
    end
  end

  initial begin
    opc_tab = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    #13;
    check("rst_out_valid", 33'(out_valid), 33'd0);
    check("rst_word", {illegal, qed_instruction}, 33'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    cycles(1);
    check("rst_in_ready", 33'(in_ready), 33'd1);

    // directed vectors, out_ready=1
    send('h33, 1, 0, 2, 3, 0, 0, 0, 0, {1'b0, 32'h003100B3});
    send('h33, 1, 0, 2, 3, 0, 0, 0, 1, {1'b0, 32'h013908B3});
    send('h13, 0, 0, 5, 0, 0, 1, 0, 1, {1'b0, 32'h001A8013});
    send('h23, 4, 2, 2, 3, 0, 0, 0, 1, {1'b0, 32'h01392223});
    send('h7F, 1, 0, 2, 3, 0, 0, 0, 1, {1'b1, 32'h00000013});
    send('h33, 17, 0, 2, 3, 0, 0, 0, 1, {1'b1, 32'h013908B3});
    cycles(2);
    check("latency_out_valid_idle", 33'(out_valid), 33'd0);

    // backpressure: A..D with the output stalled
    ready_cmd = 1'b0;
    cycles(1);
    fork
      begin
        send('h33, 1, 0, 2, 3, 0, 0, 0, 0, model('h33, 1, 0, 2, 3, 0, 0, 0, 0));
        send('h13, 2, 1, 3, 0, 0, 7, 0, 0, model('h13, 2, 1, 3, 0, 0, 7, 0, 0));
        send('h37, 3, 0, 0, 0, 0, 0, 'h12345, 1, model('h37, 3, 0, 0, 0, 0, 0, 'h12345, 1));
        send('h63, 9, 5, 4, 6, 'h55, 0, 0, 1, model('h63, 9, 5, 4, 6, 'h55, 0, 0, 1));
      end
      begin
        @(posedge clk); #3;
        check("bp_ready_after_A", 33'(in_ready), 33'd1);
        @(posedge clk); #3;
        check("bp_ready_after_B", 33'(in_ready), 33'd0);
        @(posedge clk); #3;
        check("bp_ready_held_low", 33'(in_ready), 33'd0);
        check("bp_out_valid", 33'(out_valid), 33'd1);
        ready_cmd = 1'b1;
      end
    join
    cycles(4);
    check("bp_drained", 33'(exp_q.size()), 33'd0);

    // async reset with two entries buffered
    ready_cmd = 1'b0;
    cycles(1);
    send('h33, 4, 0, 5, 6, 0, 0, 0, 0, model('h33, 4, 0, 5, 6, 0, 0, 0, 0));
    send('h33, 7, 0, 8, 9, 0, 0, 0, 0, model('h33, 7, 0, 8, 9, 0, 0, 0, 0));
    check("pre_rst_in_ready", 33'(in_ready), 33'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 33'(out_valid), 33'd0);
    exp_q.delete();
    ready_cmd = 1'b1;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    send('h6F, 5, 0, 0, 0, 0, 0, 'hABCDE, 1, model('h6F, 5, 0, 0, 0, 0, 0, 'hABCDE, 1));
    #1;
    check("post_rst_latency", 33'(out_valid), 33'd1);
    cycles(2);

    // randomized stream with random backpressure
    bp_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int op, d, f3, s1, s2, f7, imm, u;
      bit en;
      int k;
      k = int'($urandom_range(0, 12));
      op = (k < 11) ? int'(opc_tab[k]) : int'($urandom_range(0, 127));
      d = int'($urandom_range(0, 31)); f3 = int'($urandom_range(0, 7));
      s1 = int'($urandom_range(0, 31)); s2 = int'($urandom_range(0, 31));
      f7 = int'($urandom_range(0, 127)); imm = int'($urandom_range(0, 4095));
      u = int'($urandom_range(0, 1048575)); en = 1'($urandom_range(0, 1));
      send(op, d, f3, s1, s2, f7, imm, u, en, model(op, d, f3, s1, s2, f7, imm, u, en));
      if ($urandom_range(0, 3) == 0) cycles(1);
    end
    bp_mode = 1'b0;
    ready_cmd = 1'b1;
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) cycles(1);
    check("final_drain", 33'(exp_q.size()), 33'd0);
    cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
